// File: rtl/compressor_arbiter.sv
// Packet-level round-robin arbiter in front of the 256-bit Compressor.
// Locks onto one source per packet, truncates oversize packets, counts packets.
module compressor_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 256,
  parameter int MAX_BEATS = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] s_data,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  input  logic [NUM_SRC-1:0]        s_tlast,
  output logic [NUM_SRC-1:0]        s_tready,
  input  logic [NUM_SRC-1:0]        src_en,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic [2:0]                m_src_id,
  output logic                      err_oversize,
  output logic [31:0]               pkt_cnt
);

  localparam int CNT_W = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       r_state;
  logic [2:0]       r_grant;
  logic [2:0]       r_last_grant;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [31:0]      r_pkt_cnt;
  logic             r_err;

  logic [NUM_SRC-1:0] w_req;
  logic               w_found;
  logic [2:0]         w_next;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic               w_pass;
  logic               w_drain;
  logic               w_at_max;
  logic               w_xfer;

  assign w_req   = s_tvalid & src_en;
  assign w_pass  = (r_state == S_PASS);
  assign w_drain = (r_state == S_DRAIN);

  // Mux the granted source with constant part-selects only
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant == 3'(i)) begin
        w_sel_data  = s_data[i*DATA_W +: DATA_W];
        w_sel_valid = s_tvalid[i];
        w_sel_last  = s_tlast[i];
      end
    end
  end

  // Walk offsets from farthest to nearest so the nearest candidate wins
  always_comb begin
    w_found = 1'b0;
    w_next  = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (i == (int'(r_last_grant) + k) % NUM_SRC && w_req[i]) begin
          w_found = 1'b1;
          w_next  = 3'(i);
        end
      end
    end
  end

  assign w_at_max = (r_beat_cnt == LAST_BEAT);

  assign m_data   = w_pass ? w_sel_data : '0;
  assign m_tvalid = w_pass & w_sel_valid;
  assign m_tlast  = w_pass & (w_sel_last | w_at_max);
  assign w_xfer   = m_tvalid & m_tready;

  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant == 3'(i)) begin
        s_tready[i] = (w_pass & m_tready) | w_drain;
      end
    end
  end

  assign m_src_id     = r_grant;
  assign err_oversize = r_err;
  assign pkt_cnt      = r_pkt_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= 3'(NUM_SRC - 1);
      r_beat_cnt   <= '0;
      r_pkt_cnt    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_next;
            r_state <= S_PASS;
          end
        end
        S_PASS: begin
          if (w_xfer) begin
            if (w_sel_last) begin
              r_state      <= S_IDLE;
              r_last_grant <= r_grant;
              r_beat_cnt   <= '0;
              r_pkt_cnt    <= r_pkt_cnt + 32'd1;
            end else if (w_at_max) begin
              r_state    <= S_DRAIN;
              r_beat_cnt <= '0;
              r_pkt_cnt  <= r_pkt_cnt + 32'd1;
              r_err      <= 1'b1;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_sel_valid && w_sel_last) begin
            r_state      <= S_IDLE;
            r_last_grant <= r_grant;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compressor_arbiter.sv
// Directed table-driven bench for compressor_arbiter.
// Each record is one clock cycle: inputs plus the outputs expected that cycle.
module tb_compressor_arbiter;

  localparam int NS = 4;
  localparam int DW = 256;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NS*DW-1:0] s_data = '0;
  logic [NS-1:0]   s_tvalid = '0;
  logic [NS-1:0]   s_tlast = '0;
  logic [NS-1:0]   s_tready;
  logic [NS-1:0]   src_en = '0;
  logic [DW-1:0]   m_data;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready = 1'b0;
  logic [2:0]      m_src_id;
  logic            err_oversize;
  logic [31:0]     pkt_cnt;

  int checks = 0;
  int errors = 0;

  compressor_arbiter #(
    .NUM_SRC(NS), .DATA_W(DW), .MAX_BEATS(4)
  ) dut (
    .clk(clk), .reset(rst_n),
    .s_data(s_data), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .src_en(src_en),
    .m_data(m_data), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .m_src_id(m_src_id),
    .err_oversize(err_oversize), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [3:0]  en;
    logic        rdy;
    logic [7:0]  tag;
    logic        mv;
    logic        ml;
    logic [3:0]  srdy;
    logic [2:0]  id;
    logic        err;
    logic [31:0] pkt;
  } vec_t;

  vec_t vq[$];

  function automatic logic [DW-1:0] pat(input int src, input logic [7:0] tag);
    logic [DW-1:0] r;
    for (int w = 0; w < DW/32; w++)
      r[w*32 +: 32] = {8'(src), tag, 8'(w), 8'h5A};
    return r;
  endfunction

  task automatic add(input logic rst, input logic [3:0] vld,
                     input logic [3:0] lst, input logic [3:0] en,
                     input logic rdy, input logic [7:0] tag,
                     input logic mv, input logic ml,
                     input logic [3:0] srdy, input logic [2:0] id,
                     input logic err, input logic [31:0] pkt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.lst = lst; v.en = en; v.rdy = rdy;
    v.tag = tag; v.mv = mv; v.ml = ml; v.srdy = srdy; v.id = id;
    v.err = err; v.pkt = pkt;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive_data(input logic [7:0] tag);
    for (int i = 0; i < NS; i++)
      s_data[i*DW +: DW] = pat(i, tag);
  endtask

  initial begin
    logic [7:0] t;
    int srcs[5];
    int prev[5];
    logic [7:0] tag;
    int sent;

    // Reset grant
    add(0, 4'h0, 4'h0, 4'hF, 1, 8'h00, 0, 0, 4'h0, 0, 0, 0);
    add(1, 4'h5, 4'h5, 4'hF, 1, 8'h01, 0, 0, 4'h0, 0, 0, 0);
    add(1, 4'h5, 4'h5, 4'hF, 1, 8'h02, 1, 1, 4'h1, 0, 0, 0);
    add(1, 4'h4, 4'h4, 4'hF, 1, 8'h03, 0, 0, 4'h0, 0, 0, 1);
    add(1, 4'h4, 4'h4, 4'hF, 1, 8'h04, 1, 1, 4'h4, 2, 0, 1);
    add(1, 4'h0, 4'h0, 4'hF, 1, 8'h05, 0, 0, 4'h0, 2, 0, 2);
    // Round-robin, 2-beat packets from all sources
    add(0, 4'h0, 4'h0, 4'hF, 1, 8'h06, 0, 0, 4'h0, 0, 0, 0);
    srcs = '{0, 1, 2, 3, 0};
    prev = '{0, 0, 1, 2, 3};
    for (int n = 0; n < 5; n++) begin
      t = 8'(16 + 3*n);
      add(1, 4'hF, 4'h0, 4'hF, 1, t, 0, 0, 4'h0, 3'(prev[n]), 0, 32'(n));
      add(1, 4'hF, 4'h0, 4'hF, 1, t + 8'd1, 1, 0, 4'(1 << srcs[n]),
          3'(srcs[n]), 0, 32'(n));
      add(1, 4'hF, 4'hF, 4'hF, 1, t + 8'd2, 1, 1, 4'(1 << srcs[n]),
          3'(srcs[n]), 0, 32'(n));
    end
    add(1, 4'h0, 4'h0, 4'hF, 1, 8'h30, 0, 0, 4'h0, 0, 0, 5);
    // Back-pressure on source 3
    add(1, 4'h8, 4'h0, 4'hF, 1, 8'h40, 0, 0, 4'h0, 0, 0, 5);
    add(1, 4'h8, 4'h0, 4'hF, 1, 8'h41, 1, 0, 4'h8, 3, 0, 5);
    for (int k = 0; k < 3; k++)
      add(1, 4'h8, 4'h0, 4'hF, 0, 8'(8'h42 + k), 1, 0, 4'h0, 3, 0, 5);
    add(1, 4'h8, 4'h0, 4'hF, 1, 8'h45, 1, 0, 4'h8, 3, 0, 5);
    add(1, 4'h8, 4'h8, 4'hF, 1, 8'h46, 1, 1, 4'h8, 3, 0, 5);
    // Oversize: 6 beats from source 1, MAX_BEATS=4
    add(1, 4'h2, 4'h0, 4'hF, 1, 8'h50, 0, 0, 4'h0, 3, 0, 6);
    for (int k = 0; k < 3; k++)
      add(1, 4'h2, 4'h0, 4'hF, 1, 8'(8'h51 + k), 1, 0, 4'h2, 1, 0, 6);
    add(1, 4'h2, 4'h0, 4'hF, 1, 8'h54, 1, 1, 4'h2, 1, 0, 6);
    add(1, 4'h2, 4'h0, 4'hF, 0, 8'h55, 0, 0, 4'h2, 1, 1, 7);
    add(1, 4'h2, 4'h2, 4'hF, 0, 8'h56, 0, 0, 4'h2, 1, 0, 7);
    add(1, 4'h0, 4'h0, 4'hF, 1, 8'h57, 0, 0, 4'h0, 1, 0, 7);
    // Source tlast exactly on the last allowed beat
    add(1, 4'h4, 4'h0, 4'hF, 1, 8'h60, 0, 0, 4'h0, 1, 0, 7);
    for (int k = 0; k < 3; k++)
      add(1, 4'h4, 4'h0, 4'hF, 1, 8'(8'h61 + k), 1, 0, 4'h4, 2, 0, 7);
    add(1, 4'h4, 4'h4, 4'hF, 1, 8'h64, 1, 1, 4'h4, 2, 0, 7);
    add(1, 4'h0, 4'h0, 4'hF, 1, 8'h65, 0, 0, 4'h0, 2, 0, 8);
    // Enable mask 1011
    add(1, 4'hF, 4'hF, 4'hB, 1, 8'h70, 0, 0, 4'h0, 2, 0, 8);
    add(1, 4'hF, 4'hF, 4'hB, 1, 8'h71, 1, 1, 4'h8, 3, 0, 8);
    add(1, 4'hF, 4'hF, 4'hB, 1, 8'h72, 0, 0, 4'h0, 3, 0, 9);
    add(1, 4'hF, 4'hF, 4'hB, 1, 8'h73, 1, 1, 4'h1, 0, 0, 9);
    add(1, 4'hF, 4'hF, 4'hB, 1, 8'h74, 0, 0, 4'h0, 0, 0, 10);
    add(1, 4'hF, 4'hF, 4'hB, 1, 8'h75, 1, 1, 4'h2, 1, 0, 10);
    add(1, 4'hF, 4'hF, 4'hB, 1, 8'h76, 0, 0, 4'h0, 1, 0, 11);
    add(1, 4'hF, 4'hF, 4'hB, 1, 8'h77, 1, 1, 4'h8, 3, 0, 11);
    add(1, 4'h2, 4'h0, 4'hB, 1, 8'h78, 0, 0, 4'h0, 3, 0, 12);
    add(1, 4'h2, 4'h0, 4'h9, 1, 8'h79, 1, 0, 4'h2, 1, 0, 12);
    add(1, 4'h2, 4'h2, 4'h9, 1, 8'h7A, 1, 1, 4'h2, 1, 0, 12);
    add(1, 4'h2, 4'h0, 4'h9, 1, 8'h7B, 0, 0, 4'h0, 1, 0, 13);
    add(1, 4'h2, 4'h0, 4'h9, 1, 8'h7C, 0, 0, 4'h0, 1, 0, 13);
    // Reset during beat 2 of a source-2 packet
    add(1, 4'h4, 4'h0, 4'hF, 1, 8'h80, 0, 0, 4'h0, 1, 0, 13);
    add(1, 4'h4, 4'h0, 4'hF, 1, 8'h81, 1, 0, 4'h4, 2, 0, 13);
    add(0, 4'h4, 4'h0, 4'hF, 1, 8'h82, 0, 0, 4'h0, 0, 0, 0);
    add(1, 4'h5, 4'h5, 4'hF, 1, 8'h83, 0, 0, 4'h0, 0, 0, 0);
    add(1, 4'h5, 4'h5, 4'hF, 1, 8'h84, 1, 1, 4'h1, 0, 0, 0);
    add(1, 4'h0, 4'h0, 4'hF, 1, 8'h85, 0, 0, 4'h0, 0, 0, 1);

    foreach (vq[n]) begin
      @(posedge clk);
      #1;
      rst_n    = vq[n].rst;
      s_tvalid = vq[n].vld;
      s_tlast  = vq[n].lst;
      src_en   = vq[n].en;
      m_tready = vq[n].rdy;
      drive_data(vq[n].tag);
      @(negedge clk);
      chk($sformatf("v%0d_ctl", n),
          64'({m_tvalid, m_tlast, s_tready, m_src_id, err_oversize}),
          64'({vq[n].mv, vq[n].ml, vq[n].srdy, vq[n].id, vq[n].err}));
      chk($sformatf("v%0d_pkt", n), 64'(pkt_cnt), 64'(vq[n].pkt));
      if (vq[n].mv)
        chkd($sformatf("v%0d_data", n), m_data, pat(int'(vq[n].id), vq[n].tag));
    end

    // Source 1 packet of 3 beats under alternating back-pressure
    tag  = 8'd1;
    sent = 0;
    for (int cyc = 0; cyc < 30 && sent < 3; cyc++) begin
      @(posedge clk);
      #1;
      s_tvalid = 4'h2;
      src_en   = 4'hF;
      s_tlast  = (tag == 8'd3) ? 4'h2 : 4'h0;
      m_tready = cyc[0];
      drive_data(tag);
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        chkd($sformatf("bp_data%0d", sent), m_data, pat(1, tag));
        chk($sformatf("bp_last%0d", sent), 64'(m_tlast), 64'(tag == 8'd3));
        chk($sformatf("bp_id%0d", sent), 64'(m_src_id), 64'd1);
        sent++;
        tag = tag + 8'd1;
      end
    end
    chk("bp_beats", 64'(sent), 64'd3);
    @(posedge clk);
    #1;
    s_tvalid = 4'h0;
    s_tlast  = 4'h0;
    @(negedge clk);
    chk("bp_pkt", 64'(pkt_cnt), 64'd2);
    chk("bp_idle", 64'({m_tvalid, s_tready}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
